vend_ctrl_multi: RTL and testbench

//  Parametrised vending controller: accumulates coin credit and vends one of NUM_ITEMS priced items.

---
 rtl/vend_pkg.sv | 37 +++
 rtl/vend_ctrl_multi_if.sv | 37 +++
 rtl/vend_change_gen.sv | 41 ++++
 rtl/vend_ctrl_multi.sv | 183 ++++++++++++++++++
 tb/tb_vend_ctrl_multi.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the multi-item vending controller:
// coin codes, LED patterns, FSM state encoding and small helpers.
package vend_pkg;

    localparam logic [1:0] COIN_NONE = 2'b00;
    localparam logic [1:0] COIN_5    = 2'b01;
    localparam logic [1:0] COIN_10   = 2'b10;
    localparam logic [1:0] COIN_BAD  = 2'b11;

    localparam logic [2:0] LED_IDLE = 3'b001;
    localparam logic [2:0] LED_BUSY = 3'b010;
    localparam logic [2:0] LED_ERR  = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CREDIT = 2'd1,
        ST_VEND   = 2'd2,
        ST_CHANGE = 2'd3
    } vend_state_e;

    // Rupee value of a coin code; codes that carry no money report 0.
    function automatic logic [3:0] coin_value(input logic [1:0] code);
        logic [3:0] val;
        val = 4'd0;
        case (code)
            COIN_5:  val = 4'd5;
            COIN_10: val = 4'd10;
            default: val = 4'd0;
        endcase
        return val;
    endfunction

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vend_ctrl_multi_if.sv
// Coin, selection, dispense and change signals of the vending controller.
// slave is the controller's view, master is the surrounding machinery's view.
interface vend_ctrl_multi_if #(
    parameter int NUM_ITEMS = 4,
    parameter int CREDIT_W  = 8
);
    localparam int SEL_W = vend_pkg::sel_width(NUM_ITEMS);

    logic                coin_valid;
    logic [1:0]          coin;
    logic                coin_reject;
    logic                sel_valid;
    logic [SEL_W-1:0]    sel_item;
    logic                sel_nack;
    logic                cancel;
    logic                disp_valid;
    logic [SEL_W-1:0]    disp_item;
    logic                disp_ready;
    logic                chg_valid;
    logic [1:0]          chg_coin;
    logic                chg_ready;
    logic [CREDIT_W-1:0] credit;
    logic [2:0]          state_led;

    modport slave (
        input  coin_valid, coin, sel_valid, sel_item, cancel, disp_ready, chg_ready,
        output coin_reject, sel_nack, disp_valid, disp_item, chg_valid, chg_coin,
               credit, state_led
    );

    modport master (
        output coin_valid, coin, sel_valid, sel_item, cancel, disp_ready, chg_ready,
        input  coin_reject, sel_nack, disp_valid, disp_item, chg_valid, chg_coin,
               credit, state_led
    );

endinterface

// File: rtl/vend_change_gen.sv
// Change sequencer: presents one coin at a time for the credit that will be
// held next cycle, biggest coin first, and holds it until the hopper takes it.
module vend_change_gen
    import vend_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                active_nxt,
    input  logic [CREDIT_W-1:0] credit_nxt,
    input  logic                chg_ready,
    output logic                chg_valid,
    output logic [1:0]          chg_coin,
    output logic                fire,
    output logic [CREDIT_W-1:0] coin_val
);

    localparam logic [CREDIT_W-1:0] TEN = CREDIT_W'(10);

    logic issue_nxt;

    assign issue_nxt = active_nxt && (credit_nxt != '0);
    assign fire      = chg_valid && chg_ready;
    assign coin_val  = CREDIT_W'(coin_value(chg_coin));

    // Credit only moves on a handshake, so the coin stays stable while offered.
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_valid <= 1'b0;
            chg_coin  <= COIN_NONE;
        end else begin
            chg_valid <= issue_nxt;
            if (issue_nxt)
                chg_coin <= (credit_nxt >= TEN) ? COIN_10 : COIN_5;
            else
                chg_coin <= COIN_NONE;
        end
    end

endmodule

// File: rtl/vend_ctrl_multi.sv
// Multi-item vending controller: accumulates coin credit, vends a priced item,
// returns change through vend_change_gen; cancel and idle timeout refund credit.
module vend_ctrl_multi
    import vend_pkg::*;
#(
    parameter int                          NUM_ITEMS   = 4,
    parameter int                          CREDIT_W    = 8,
    parameter int                          MAX_CREDIT  = 50,
    parameter logic [NUM_ITEMS*CREDIT_W-1:0] PRICES    = {8'd10, 8'd25, 8'd20, 8'd15},
    parameter int                          TIMEOUT_CYC = 1000
) (
    input logic             clk,
    input logic             rst,
    vend_ctrl_multi_if.slave bus
);

    localparam int SEL_W = sel_width(NUM_ITEMS);
    localparam int TMR_W = $clog2(TIMEOUT_CYC);

    if (NUM_ITEMS < 1) begin : g_bad_items
        $error("NUM_ITEMS must be at least 1");
    end
    if (TIMEOUT_CYC < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 2");
    end
    if ($clog2(MAX_CREDIT + 1) > CREDIT_W) begin : g_bad_max
        $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end

    logic [CREDIT_W-1:0] price_tab [NUM_ITEMS];

    for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
        localparam int P = int'(PRICES[i*CREDIT_W +: CREDIT_W]);
        if ((P % 5 != 0) || (P > MAX_CREDIT)) begin : g_bad_price
            $error("item price must be a multiple of 5 and not above MAX_CREDIT");
        end
        assign price_tab[i] = PRICES[i*CREDIT_W +: CREDIT_W];
    end

    vend_state_e         state, state_nxt;
    logic [CREDIT_W-1:0] credit_q, credit_nxt;
    logic [TMR_W-1:0]    timer_q, timer_nxt;
    logic [SEL_W-1:0]    disp_item_q, disp_item_nxt;
    logic                reject_nxt, nack_nxt, disp_valid_nxt;
    logic [2:0]          led_nxt;

    logic [CREDIT_W-1:0] price;
    logic                sel_hit;
    logic [CREDIT_W:0]   credit_sum;
    logic                coin_any, coin_good, coin_fits, sel_afford, vend_done, timeout;
    logic                chg_fire;
    logic [CREDIT_W-1:0] chg_val;

    // Price lookup; an index with no matching item leaves sel_hit low.
    always_comb begin
        price   = '0;
        sel_hit = 1'b0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (bus.sel_item == SEL_W'(i)) begin
                price   = price_tab[i];
                sel_hit = 1'b1;
            end
        end
    end

    assign credit_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(bus.coin));
    assign coin_any   = bus.coin_valid && (bus.coin != COIN_NONE);
    assign coin_good  = bus.coin_valid && ((bus.coin == COIN_5) || (bus.coin == COIN_10));
    assign coin_fits  = credit_sum <= (CREDIT_W+1)'(MAX_CREDIT);
    assign sel_afford = sel_hit && (credit_q >= price);
    assign vend_done  = bus.disp_valid && bus.disp_ready;
    assign timeout    = timer_q == TMR_W'(TIMEOUT_CYC - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= ST_IDLE;
            credit_q        <= '0;
            timer_q         <= '0;
            disp_item_q     <= '0;
            bus.disp_valid  <= 1'b0;
            bus.coin_reject <= 1'b0;
            bus.sel_nack    <= 1'b0;
            bus.state_led   <= LED_IDLE;
        end else begin
            state           <= state_nxt;
            credit_q        <= credit_nxt;
            timer_q         <= timer_nxt;
            disp_item_q     <= disp_item_nxt;
            bus.disp_valid  <= disp_valid_nxt;
            bus.coin_reject <= reject_nxt;
            bus.sel_nack    <= nack_nxt;
            bus.state_led   <= led_nxt;
        end
    end

    // Priority in IDLE/CREDIT is cancel, then selection, then coin, then timeout.
    always_comb begin
        state_nxt     = state;
        credit_nxt    = credit_q;
        timer_nxt     = timer_q;
        disp_item_nxt = disp_item_q;
        case (state)
            ST_IDLE: begin
                timer_nxt = '0;
                if (!bus.cancel && !bus.sel_valid && coin_good) begin
                    credit_nxt = CREDIT_W'(coin_value(bus.coin));
                    state_nxt  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (bus.cancel) begin
                    state_nxt = ST_CHANGE;
                    timer_nxt = '0;
                end else if (bus.sel_valid && sel_afford) begin
                    credit_nxt    = credit_q - price;
                    disp_item_nxt = bus.sel_item;
                    state_nxt     = ST_VEND;
                    timer_nxt     = '0;
                end else if (!bus.sel_valid && coin_good && coin_fits) begin
                    credit_nxt = credit_sum[CREDIT_W-1:0];
                    timer_nxt  = '0;
                end else if (timeout) begin
                    state_nxt = ST_CHANGE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer_q + TMR_W'(1);
                end
            end
            ST_VEND: begin
                if (vend_done)
                    state_nxt = (credit_q != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                if (credit_q == '0) begin
                    state_nxt = ST_IDLE;
                end else if (chg_fire) begin
                    credit_nxt = credit_q - chg_val;
                    if (credit_nxt == '0)
                        state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        reject_nxt = 1'b0;
        nack_nxt   = 1'b0;
        if ((state == ST_IDLE) || (state == ST_CREDIT)) begin
            nack_nxt   = bus.sel_valid &&
                         (bus.cancel || (state == ST_IDLE) || !sel_afford);
            reject_nxt = coin_any &&
                         (bus.cancel || bus.sel_valid || (bus.coin == COIN_BAD) ||
                          ((state == ST_CREDIT) && !coin_fits));
        end else begin
            nack_nxt   = bus.sel_valid;
            reject_nxt = bus.coin_valid;
        end
        disp_valid_nxt = state_nxt == ST_VEND;
        if (reject_nxt || nack_nxt)
            led_nxt = LED_ERR;
        else
            led_nxt = (state_nxt == ST_IDLE) ? LED_IDLE : LED_BUSY;
    end

    vend_change_gen #(
        .CREDIT_W (CREDIT_W)
    ) u_change (
        .clk        (clk),
        .rst        (rst),
        .active_nxt (state_nxt == ST_CHANGE),
        .credit_nxt (credit_nxt),
        .chg_ready  (bus.chg_ready),
        .chg_valid  (bus.chg_valid),
        .chg_coin   (bus.chg_coin),
        .fire       (chg_fire),
        .coin_val   (chg_val)
    );

    assign bus.credit    = credit_q;
    assign bus.disp_item = disp_item_q;

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed-vector bench for vend_ctrl_multi: a table of per-cycle stimulus with
// hand-computed outputs, plus hand sequences for timeout and reset-while-vending.
module tb_vend_ctrl_multi;

    localparam int TO = 1000;
    localparam int L1 = 1;
    localparam int L2 = 2;
    localparam int L4 = 4;

    typedef struct {
        logic       coin_valid;
        logic [1:0] coin;
        logic       sel_valid;
        logic [1:0] sel_item;
        logic       cancel;
        logic       disp_ready;
        logic       chg_ready;
        logic       rej;
        logic       nack;
        logic       dv;
        logic [1:0] di;
        logic       cv;
        logic [1:0] cc;
        logic [7:0] credit;
        logic [2:0] led;
    } vec_t;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    vend_ctrl_multi_if #(.NUM_ITEMS(4), .CREDIT_W(8)) bus ();

    vend_ctrl_multi #(
        .NUM_ITEMS   (4),
        .CREDIT_W    (8),
        .MAX_CREDIT  (50),
        .PRICES      ({8'd10, 8'd25, 8'd20, 8'd15}),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t v(input int ci, input int co, input int s, input int it,
                               input int ca, input int dr, input int cr,
                               input int rj, input int nk, input int dv, input int di,
                               input int cv, input int cc, input int crd, input int led);
        return '{1'(ci), 2'(co), 1'(s), 2'(it), 1'(ca), 1'(dr), 1'(cr),
                 1'(rj), 1'(nk), 1'(dv), 2'(di), 1'(cv), 2'(cc), 8'(crd), 3'(led)};
    endfunction

    task automatic applyStimulus(input vec_t s);
        bus.coin_valid = s.coin_valid;
        bus.coin       = s.coin;
        bus.sel_valid  = s.sel_valid;
        bus.sel_item   = s.sel_item;
        bus.cancel     = s.cancel;
        bus.disp_ready = s.disp_ready;
        bus.chg_ready  = s.chg_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t e, input string tag);
        checkField({tag, " coin_reject"}, 32'(bus.coin_reject), 32'(e.rej));
        checkField({tag, " sel_nack"},    32'(bus.sel_nack),    32'(e.nack));
        checkField({tag, " disp_valid"},  32'(bus.disp_valid),  32'(e.dv));
        checkField({tag, " chg_valid"},   32'(bus.chg_valid),   32'(e.cv));
        checkField({tag, " credit"},      32'(bus.credit),      32'(e.credit));
        checkField({tag, " state_led"},   32'(bus.state_led),   32'(e.led));
        if (e.dv)
            checkField({tag, " disp_item"}, 32'(bus.disp_item), 32'(e.di));
        if (e.cv)
            checkField({tag, " chg_coin"}, 32'(bus.chg_coin), 32'(e.cc));
    endtask

    initial begin
        // 10+5, buy item0 (15), actuator takes 3 cycles, no change due
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,L1));
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,10,L2));
        tbl.push_back(v(1,1,0,0,0,0,0, 0,0,0,0,0,0,15,L2));
        tbl.push_back(v(0,0,1,0,0,0,0, 0,0,1,0,0,0, 0,L2));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,1,0,0,0, 0,L2));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,1,0,0,0, 0,L2));
        tbl.push_back(v(0,0,0,0,0,1,0, 0,0,0,0,0,0, 0,L1));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,L1));
        // 30 in, buy item1 (20), one 10 coin back after a stalled hopper cycle
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,10,L2));
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,20,L2));
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,30,L2));
        tbl.push_back(v(0,0,1,1,0,0,0, 0,0,1,1,0,0,10,L2));
        tbl.push_back(v(0,0,0,0,0,1,0, 0,0,0,0,1,2,10,L2));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,1,2,10,L2));
        tbl.push_back(v(0,0,0,0,0,0,1, 0,0,0,0,0,0, 0,L1));
        // invalid coin code in IDLE
        tbl.push_back(v(1,3,0,0,0,0,0, 1,0,0,0,0,0, 0,L4));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,L1));
        // 5 credit cannot buy item0; cancel refunds one 5 coin
        tbl.push_back(v(1,1,0,0,0,0,0, 0,0,0,0,0,0, 5,L2));
        tbl.push_back(v(0,0,1,0,0,0,0, 0,1,0,0,0,0, 5,L4));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0, 5,L2));
        tbl.push_back(v(0,0,0,0,1,0,0, 0,0,0,0,1,1, 5,L2));
        tbl.push_back(v(0,0,0,0,0,0,1, 0,0,0,0,0,0, 0,L1));
        // fill to exactly 50, overflow coin, then cancel+sel+coin together
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,10,L2));
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,20,L2));
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,30,L2));
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,40,L2));
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,50,L2));
        tbl.push_back(v(1,1,0,0,0,0,0, 1,0,0,0,0,0,50,L4));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,50,L2));
        tbl.push_back(v(1,2,1,0,1,0,0, 1,1,0,0,1,2,50,L4));
        tbl.push_back(v(0,0,0,0,0,0,1, 0,0,0,0,1,2,40,L2));
        tbl.push_back(v(1,1,0,0,0,0,1, 1,0,0,0,1,2,30,L4));
        tbl.push_back(v(0,0,1,0,0,0,1, 0,1,0,0,1,2,20,L4));
        tbl.push_back(v(0,0,0,0,0,0,1, 0,0,0,0,1,2,10,L2));
        tbl.push_back(v(0,0,0,0,0,0,1, 0,0,0,0,0,0, 0,L1));
        // selection with a coin in the same cycle; coin inserted while vending
        tbl.push_back(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,10,L2));
        tbl.push_back(v(1,1,1,2,0,0,0, 1,1,0,0,0,0,10,L4));
        tbl.push_back(v(1,2,1,3,0,0,0, 1,0,1,3,0,0, 0,L4));
        tbl.push_back(v(1,1,0,0,0,1,0, 1,0,0,0,0,0, 0,L4));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,L1));
        // IDLE: selection refused, code 00 ignored, coin with cancel rejected
        tbl.push_back(v(0,0,1,0,0,0,0, 0,1,0,0,0,0, 0,L4));
        tbl.push_back(v(1,0,0,0,0,0,0, 0,0,0,0,0,0, 0,L1));
        tbl.push_back(v(1,1,0,0,1,0,0, 1,0,0,0,0,0, 0,L4));
        tbl.push_back(v(0,0,0,0,0,0,0, 0,0,0,0,0,0, 0,L1));

        rst = 1'b1;
        applyStimulus(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
        applyStimulus(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1), "reset");
        checkField("reset disp_item", 32'(bus.disp_item), 32'd0);
        checkField("reset chg_coin",  32'(bus.chg_coin),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("vec%0d", i));
        end

        // Timeout: an accepted coin restarts the idle count, then 10 and 5 are refunded
        applyStimulus(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,10,L2));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,10,L2), "to_coin10");
        for (int i = 0; i < TO - 2; i++)
            applyStimulus(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,10,L2), "to_hold");
        applyStimulus(v(1,1,0,0,0,0,0, 0,0,0,0,0,0,15,L2));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,15,L2), "to_coin5");
        for (int i = 0; i < TO - 1; i++)
            applyStimulus(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,15,L2), "to_notyet");
        applyStimulus(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,1,2,15,L2), "to_fire");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
            checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,1,2,15,L2), $sformatf("to_stall%0d", i));
        end
        applyStimulus(v(0,0,0,0,0,0,1, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,1,1,5,L2), "to_chg10");
        applyStimulus(v(0,0,0,0,0,0,1, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1), "to_chg5");

        // Reset while a dispense is pending drops it and discards leftover credit
        applyStimulus(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,10,L2), "rv_coin1");
        applyStimulus(v(1,2,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,20,L2), "rv_coin2");
        applyStimulus(v(0,0,1,3,0,0,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,1,3,0,0,10,L2), "rv_vend");
        rst = 1'b1;
        applyStimulus(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1), "rv_reset");
        rst = 1'b0;
        applyStimulus(v(0,0,0,0,0,1,0, 0,0,0,0,0,0,0,L1));
        checkOutput(v(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,L1), "rv_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
